// File: rtl/aq_spsram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aq_spsram_ctrl_pkg
//   Shared definitions for the 64x58 single-port SRAM controller:
//   - default SRAM geometry (ADDR_WIDTH, DATA_WIDTH)
//   - read-starvation threshold (STARVE_LIMIT)
//   - controller state enumeration (INV = invalidate sweep, RUN = arbitrate)
//   - helper to size the starvation counter for a given limit
// -----------------------------------------------------------------------------
package aq_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH   = 6;
  localparam int DATA_WIDTH   = 58;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic {
    INV = 1'b0,
    RUN = 1'b1
  } ctrl_state_e;

  // The counter must be able to hold the limit value itself.
  function automatic int starve_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/aq_spsram_ctrl_sweep.sv
// -----------------------------------------------------------------------------
// aq_spsram_ctrl_sweep
//   Address generator for the full-array invalidate sweep. The counter steps
//   once per cycle while active and naturally wraps back to 0 after the last
//   entry, so it is already at 0 whenever the next sweep begins.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset, counter -> 0
//   active_i   : controller is in the sweep state; advance the counter
//   restart_i  : force the counter to 0 for the next cycle
//   cnt_o      : current sweep address
//   done_o     : active and pointing at the last entry (final sweep cycle)
// -----------------------------------------------------------------------------
module aq_spsram_ctrl_sweep #(
  parameter int ADDR_WIDTH = aq_spsram_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  active_i,
  input  logic                  restart_i,
  output logic [ADDR_WIDTH-1:0] cnt_o,
  output logic                  done_o
);

  import aq_spsram_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      // Wraps from the last entry back to 0 on its own.
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = active_i && (cnt_q == {ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/aq_spsram_64x58_ctrl.sv
// -----------------------------------------------------------------------------
// aq_spsram_64x58_ctrl
//   Controller for a 64x58 single-port SRAM with active-low enables.
//   After reset (and on request) it sweeps every entry to zero, then
//   arbitrates one read or one write per cycle. Writes normally win; a read
//   that has been refused STARVE_LIMIT cycles in a row is forced through.
//   Read data comes back one cycle after the read grant.
//
// Ports
//   forever_cpuclk : sole clock, rising edge
//   cpurst_b       : asynchronous active-low reset
//   inv_req        : one-cycle pulse, start a full invalidate sweep
//   inv_busy       : sweep in progress
//   rd_req/rd_addr : read request
//   rd_gnt         : read accepted this cycle (combinational)
//   rd_vld/rd_data : read return, data forced to 0 when not valid
//   wr_req/wr_addr/wr_data/wr_mask : write request, mask bit 1 = write bit
//   wr_gnt         : write accepted this cycle (combinational)
//   sram_a/sram_cen/sram_gwen/sram_wen/sram_d : SRAM drive (enables low)
//   sram_q         : SRAM read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module aq_spsram_64x58_ctrl #(
  parameter int ADDR_WIDTH   = aq_spsram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = aq_spsram_ctrl_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = aq_spsram_ctrl_pkg::STARVE_LIMIT
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  import aq_spsram_ctrl_pkg::*;

  localparam int STARVE_W = starve_width(STARVE_LIMIT);

  ctrl_state_e           state_q;
  ctrl_state_e           state_d;
  logic [STARVE_W-1:0]   starve_q;
  logic [STARVE_W-1:0]   starve_d;
  logic                  rd_vld_q;
  logic                  rd_vld_d;

  logic                  in_inv;
  logic                  in_run;
  logic                  sweep_restart;
  logic                  sweep_done;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  starve_hit;
  logic                  arb_en;
  logic                  rd_wins;

  assign in_inv = (state_q == INV);
  assign in_run = (state_q == RUN);

  // A new sweep always starts from entry 0, even if requested from RUN.
  assign sweep_restart = in_run && inv_req;

  aq_spsram_ctrl_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweep (
    .clk_i     (forever_cpuclk),
    .rst_n_i   (cpurst_b),
    .active_i  (in_inv),
    .restart_i (sweep_restart),
    .cnt_o     (sweep_addr),
    .done_o    (sweep_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= INV;
      starve_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // inv_req is deliberately not looked at here: a sweep cannot be
      // restarted or queued while one is running.
      INV: if (sweep_done) state_d = RUN;
      RUN: if (inv_req)    state_d = INV;
      default: state_d = INV;
    endcase
  end

  // Starvation counter: counts consecutive RUN cycles in which a pending read
  // was refused. It saturates at the limit so a refusal caused by inv_req
  // while already at the limit cannot wrap it.
  assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!rd_req || rd_gnt) begin
      starve_d = '0;
    end else if (in_run && !starve_hit) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Read return is simply the grant delayed by one cycle; a state change to
  // INV does not touch it, so an in-flight read still returns.
  assign rd_vld_d = rd_gnt;

  // ---------------------------------------------------------------------------
  // FSM: output logic (arbitration and SRAM mux)
  // ---------------------------------------------------------------------------
  assign arb_en  = in_run && !inv_req;
  assign rd_wins = rd_req && (!wr_req || starve_hit);

  always_comb begin
    rd_gnt    = arb_en && rd_wins;
    wr_gnt    = arb_en && wr_req && !rd_wins;
    inv_busy  = in_inv;

    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;

    // The sweep drive is gated by the reset input itself so the SRAM stays
    // deselected for the whole time reset is held, not just from the next edge.
    if (in_inv && cpurst_b) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = sweep_addr;
      sram_d    = '0;
    end else if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_mask;
      sram_a    = wr_addr;
      sram_d    = wr_data;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = rd_addr;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_vld_q ? sram_q : '0;

endmodule

// File: doc/aq_spsram_64x58_ctrl.md
AQ_SPSRAM_64X58_CTRL -- requirements
Module: aq_spsram_64x58_ctrl

Interface
REQ-001 ADDR_WIDTH, 6, SRAM address width (64 entries).
REQ-002 DATA_WIDTH, 58, SRAM word width.
REQ-003 STARVE_LIMIT, 4, consecutive read-denied cycles before read is forced to win.
REQ-004 forever_cpuclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 cpurst_b  in  1  reset, asynchronous assert, active-low.
REQ-006 inv_req  in  1  single-cycle pulse requesting a full invalidate sweep.
REQ-007 inv_busy  out  1  high while the sweep FSM is in INV.
REQ-008 rd_req  in  1 / rd_addr  in  ADDR_WIDTH  read request and address.
REQ-009 rd_gnt  out  1  read accepted this cycle (combinational from requests and state).
REQ-010 rd_vld  out  1 / rd_data  out  DATA_WIDTH  read return.
REQ-011 wr_req  in  1 / wr_addr  in  ADDR_WIDTH / wr_data  in  DATA_WIDTH / wr_mask  in  DATA_WIDTH (1 = write bit)  write request.
REQ-012 wr_gnt  out  1  write accepted this cycle.
REQ-013 sram_a  out  ADDR_WIDTH / sram_cen  out  1 / sram_gwen  out  1 / sram_wen  out  DATA_WIDTH / sram_d  out  DATA_WIDTH  SRAM drive, all active-low enables.
REQ-014 sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access and held while sram_cen=1.

Function
REQ-015 FSM states: INV (sweep), RUN (arbitrate); exit from reset SHALL enter INV with sweep counter 0.
REQ-016 INV: each cycle SHALL drive sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=counter; counter +1 per cycle.
REQ-017 Counter at 63 SHALL transition to RUN on the next edge; sweep lasts exactly 64 cycles; counter wraps to 0.
REQ-018 In INV, rd_gnt and wr_gnt SHALL be 0; inv_req SHALL be ignored (no restart, no queueing).
REQ-019 In RUN, inv_req=1 SHALL take priority over rd_req/wr_req that cycle (no grants) and enter INV with counter 0 next cycle.
REQ-020 In RUN, default priority write over read; at most one grant per cycle.
REQ-021 Starvation counter SHALL increment each RUN cycle with rd_req=1 and rd_gnt=0, clear on rd_gnt or rd_req=0; when it equals STARVE_LIMIT, read SHALL win over write.
REQ-022 Write grant: sram_cen=0, sram_gwen=0, sram_a=wr_addr, sram_d=wr_data, sram_wen=~wr_mask.
REQ-023 Read grant: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=rd_addr.
REQ-024 No grant: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a and sram_d 0.
REQ-025 rd_vld SHALL be 1 exactly one cycle after rd_gnt; rd_data SHALL equal sram_q when rd_vld=1, else 0.
REQ-026 Write then read of the same address in consecutive cycles SHALL return the newly written masked data (no bypass needed; SRAM order guarantees it).
REQ-027 Entering INV from RUN SHALL not suppress rd_vld for a read granted the previous cycle.

Reset
REQ-028 cpurst_b low SHALL asynchronously force: state INV, sweep counter 0, starvation counter 0, rd_vld 0.
REQ-029 During reset outputs SHALL be: inv_busy 1, rd_gnt 0, wr_gnt 0, rd_data 0, sram_cen 1, sram_gwen 1, sram_wen all 1.
REQ-030 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Structure
REQ-031 Shared package aq_spsram_ctrl_pkg SHALL hold the state enumeration (INV, RUN), ADDR_WIDTH/DATA_WIDTH defaults and STARVE_LIMIT.
REQ-032 One sub-module aq_spsram_ctrl_sweep SHALL hold the sweep counter and done flag; arbitration and SRAM muxing stay in the top.

Verification
REQ-033 Release reset -> inv_busy high 64 cycles, sram_a 0..63 with sram_wen=0, sram_d=0, then RUN; rd of addr 5 returns 0.
REQ-034 RUN: write addr 10 data 0x2AAAAAAAAAAAAAA mask all 1, next cycle read addr 10 -> rd_vld two cycles after write grant, rd_data 0x2AAAAAAAAAAAAAA.
REQ-035 Write addr 3 data all 1 mask 0x00000000000FFFF onto zeroed entry -> read returns 0x00000000000FFFF.
REQ-036 wr_req and rd_req held high continuously -> wr_gnt 4 cycles, then rd_gnt 1 cycle, pattern repeating.
REQ-037 Assert cpurst_b low at sweep address 30 for 2 cycles -> sram_cen 1 during reset, sweep restarts at 0, 64 more cycles.
REQ-038 In RUN, inv_req with rd_req and wr_req same cycle -> no grant that cycle, inv_busy next cycle, requests granted only after 64-cycle sweep.
